// File: rtl/hdmi_timing_gen_pkg.sv
// Shared constants and types for the HDMI video timing generator.
package hdmi_timing_gen_pkg;

  // Pixel word width (RGB888)
  localparam int unsigned PIX_W = 24;

  // 1080p60 timing set (148.5 MHz pixel clock)
  localparam int unsigned H1080_ACTIVE = 1920;
  localparam int unsigned H1080_FP     = 88;
  localparam int unsigned H1080_SYNC   = 44;
  localparam int unsigned H1080_BP     = 148;
  localparam int unsigned V1080_ACTIVE = 1080;
  localparam int unsigned V1080_FP     = 4;
  localparam int unsigned V1080_SYNC   = 5;
  localparam int unsigned V1080_BP     = 36;

  // 720p60 timing set (74.25 MHz pixel clock)
  localparam int unsigned H720_ACTIVE  = 1280;
  localparam int unsigned H720_FP      = 110;
  localparam int unsigned H720_SYNC    = 40;
  localparam int unsigned H720_BP      = 220;
  localparam int unsigned V720_ACTIVE  = 720;
  localparam int unsigned V720_FP      = 5;
  localparam int unsigned V720_SYNC    = 5;
  localparam int unsigned V720_BP      = 20;

  // Raw (polarity-free) timing flags carried down the pipeline
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic fs;
  } vtiming_t;

  // Pixel payload as delivered to the encoder
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Total period of one axis (line or frame) in counter units
  function automatic int unsigned axis_total(input int unsigned active,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_hv_counter.sv
// Free-running horizontal/vertical position counters with wrap logic.
module video_hv_counter
  import hdmi_timing_gen_pkg::*;
#(
  parameter int unsigned H_TOTAL = 2200,
  parameter int unsigned V_TOTAL = 1125,
  parameter int unsigned CNT_W   = 12
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic [CNT_W-1:0] h_cnt_o,
  output logic [CNT_W-1:0] v_cnt_o
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

  // Next position: h wraps every line, v advances on h wrap and wraps per frame
  always_comb begin
    h_cnt_d = h_cnt_q + CNT_W'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      if (v_cnt_q == V_LAST) begin
        v_cnt_d = '0;
      end else begin
        v_cnt_d = v_cnt_q + CNT_W'(1);
      end
    end
  end

  // Position registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt_o = h_cnt_q;
  assign v_cnt_o = v_cnt_q;

endmodule

// File: rtl/hdmi_timing_gen.sv
// Video timing generator: decodes sync/active regions from the H/V counters,
// pops the pixel FIFO one cycle per active pixel and presents syncs, DE and
// pixel data aligned three cycles after the counter position.
module hdmi_timing_gen
  import hdmi_timing_gen_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H1080_ACTIVE,
  parameter int unsigned H_FP     = H1080_FP,
  parameter int unsigned H_SYNC   = H1080_SYNC,
  parameter int unsigned H_BP     = H1080_BP,
  parameter int unsigned V_ACTIVE = V1080_ACTIVE,
  parameter int unsigned V_FP     = V1080_FP,
  parameter int unsigned V_SYNC   = V1080_SYNC,
  parameter int unsigned V_BP     = V1080_BP,
  parameter logic        HS_POL   = 1'b1,
  parameter logic        VS_POL   = 1'b1,
  parameter int unsigned CNT_W    = 12
) (
  input  logic             hdmiclk,
  input  logic             hdmi_rst_n,
  output logic             rd_fifo_en,
  input  logic [PIX_W-1:0] rd_fifo_data,
  input  logic             rd_fifo_empty,
  output logic             video_hs,
  output logic             video_vs,
  output logic             video_de,
  output logic [PIX_W-1:0] video_data,
  output logic             frame_start,
  output logic             underflow
);

  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  // Region boundaries in counter units
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_BEG  = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] V_ACT_BEG  = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_SYNC + V_BP + V_ACTIVE);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;

  // Stage-0 decode and pipeline registers
  vtiming_t st0;
  vtiming_t s1_q, s1_d;
  vtiming_t s2_q, s2_d;

  logic     rd_fifo_en_q, rd_fifo_en_d;
  logic     video_hs_q, video_hs_d;
  logic     video_vs_q, video_vs_d;
  logic     video_de_q, video_de_d;
  rgb888_t  video_data_q, video_data_d;
  logic     frame_start_q, frame_start_d;
  logic     underflow_q, underflow_d;

  video_hv_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .CNT_W   (CNT_W)
  ) u_hv_counter (
    .clk_i   (hdmiclk),
    .rst_ni  (hdmi_rst_n),
    .h_cnt_o (h_cnt),
    .v_cnt_o (v_cnt)
  );

  // Region decode from the current counter position
  always_comb begin
    st0    = '0;
    st0.hs = (h_cnt < H_SYNC_END);
    st0.vs = (v_cnt < V_SYNC_END);
    st0.de = (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END) &&
             (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
    st0.fs = (h_cnt == H_ACT_BEG) && (v_cnt == V_ACT_BEG);
  end

  // Next-state for the three pipeline stages and the sticky underflow flag
  always_comb begin
    s1_d          = st0;
    s2_d          = s1_q;
    rd_fifo_en_d  = st0.de;
    video_hs_d    = s2_q.hs ^ ~HS_POL;
    video_vs_d    = s2_q.vs ^ ~VS_POL;
    video_de_d    = s2_q.de;
    frame_start_d = s2_q.fs;
    video_data_d  = '0;
    if (s2_q.de) begin
      video_data_d = rgb888_t'(rd_fifo_data);
    end
    underflow_d   = underflow_q | (rd_fifo_en_q & rd_fifo_empty);
  end

  // Pipeline and output registers; syncs reset to their inactive level
  always_ff @(posedge hdmiclk or negedge hdmi_rst_n) begin
    if (!hdmi_rst_n) begin
      s1_q          <= '0;
      s2_q          <= '0;
      rd_fifo_en_q  <= 1'b0;
      video_hs_q    <= ~HS_POL;
      video_vs_q    <= ~VS_POL;
      video_de_q    <= 1'b0;
      video_data_q  <= '0;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      rd_fifo_en_q  <= rd_fifo_en_d;
      video_hs_q    <= video_hs_d;
      video_vs_q    <= video_vs_d;
      video_de_q    <= video_de_d;
      video_data_q  <= video_data_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
    end
  end

  assign rd_fifo_en  = rd_fifo_en_q;
  assign video_hs    = video_hs_q;
  assign video_vs    = video_vs_q;
  assign video_de    = video_de_q;
  assign video_data  = video_data_q;
  assign frame_start = frame_start_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Bench for hdmi_timing_gen: small timing instance checked against an
// arithmetic reference model, plus a 1080p instance for line period checks.
module tb_hdmi_timing_gen;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int FS_POS = (VS + VB) * HT + HS + HB;
  localparam int NPIX = HA * VA;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst_hd_n = 1'b0;
  logic        rd_fifo_en, rd_fifo_empty;
  logic [23:0] fifo_dout;
  logic        video_hs, video_vs, video_de, frame_start, underflow;
  logic [23:0] video_data;
  logic        hd_en, hd_hs, hd_vs, hd_de, hd_fs, hd_uf;
  logic [23:0] hd_data;

  int          tests = 0;
  int          fails = 0;
  int          n;
  int          pop_cnt;
  bit          mode_rand = 1'b0;
  bit          inject_uf = 1'b0;
  bit          noise = 1'b0;
  logic [23:0] rand_pix [64];

  always #5 clk = ~clk;

  hdmi_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(4)
  ) u_dut (
    .hdmiclk(clk), .hdmi_rst_n(rst_n),
    .rd_fifo_en(rd_fifo_en), .rd_fifo_data(fifo_dout), .rd_fifo_empty(rd_fifo_empty),
    .video_hs(video_hs), .video_vs(video_vs), .video_de(video_de),
    .video_data(video_data), .frame_start(frame_start), .underflow(underflow)
  );

  hdmi_timing_gen u_dut_hd (
    .hdmiclk(clk), .hdmi_rst_n(rst_hd_n),
    .rd_fifo_en(hd_en), .rd_fifo_data(24'h0), .rd_fifo_empty(1'b0),
    .video_hs(hd_hs), .video_vs(hd_vs), .video_de(hd_de),
    .video_data(hd_data), .frame_start(hd_fs), .underflow(hd_uf)
  );

  // ---------------- reference model (position p = counter value index) ----
  function automatic bit pos_active(input int p);
    int r, h, v;
    r = p % FT; h = r % HT; v = r / HT;
    return (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
  endfunction

  // Number of active pixels decoded at positions strictly before p
  function automatic int pops_before(input int p);
    int r, h, v, lines, part;
    r = p % FT; h = r % HT; v = r / HT;
    lines = v - (VS + VB);
    if (lines < 0) lines = 0;
    if (lines > VA) lines = VA;
    part = 0;
    if (v >= VS + VB && v < VS + VB + VA) begin
      part = h - (HS + HB);
      if (part < 0) part = 0;
      if (part > HA) part = HA;
    end
    return (p / FT) * NPIX + lines * HA + part;
  endfunction

  function automatic logic [23:0] pix_val(input int idx);
    if (mode_rand) return rand_pix[idx % 64];
    return 24'(idx);
  endfunction

  // Expected outputs after k clock edges since reset release
  function automatic bit exp_en(input int k);
    return (k >= 1) && pos_active(k - 1);
  endfunction
  function automatic bit exp_hs(input int k);
    return (k >= 3) && (((k - 3) % HT) < HS);
  endfunction
  function automatic bit exp_vs(input int k);
    return (k >= 3) && ((((k - 3) % FT) / HT) < VS);
  endfunction
  function automatic bit exp_de(input int k);
    return (k >= 3) && pos_active(k - 3);
  endfunction
  function automatic bit exp_fs(input int k);
    return (k >= 3) && (((k - 3) % FT) == FS_POS);
  endfunction
  function automatic bit exp_uf(input int k);
    return inject_uf && (k >= 1) && (pops_before(k - 1) >= 5);
  endfunction
  function automatic logic [23:0] exp_data(input int k);
    if (!exp_de(k)) return 24'h0;
    return pix_val(pops_before(k - 3));
  endfunction

  // Edge counter since release
  always @(posedge clk or negedge rst_n)
    if (!rst_n) n <= 0;
    else        n <= n + 1;

  // Pixel FIFO model: data valid the cycle after the pop is sampled
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pop_cnt   <= 0;
      fifo_dout <= 24'h0;
    end else if (rd_fifo_en) begin
      fifo_dout <= pix_val(pop_cnt);
      pop_cnt   <= pop_cnt + 1;
    end

  // Empty during the 5th pop when injecting; random empty only on idle cycles
  assign rd_fifo_empty = (inject_uf && pop_cnt == 4) || (noise && !exp_en(n));

  task automatic do_reset(input bit rnd, input bit inj);
    rst_n = 1'b0;
    mode_rand = rnd;
    inject_uf = inj;
    noise = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1 rst_n = 1'b1; rst_hd_n = 1'b1;
    #1 rst_n = 1'b0; rst_hd_n = 1'b0;
    #1;
    tests++;
    if ({rd_fifo_en, video_hs, video_vs, video_de, video_data, frame_start, underflow} !== 30'h0) begin
      fails++;
      $display("FAIL reset_async: got en/hs/vs/de/data/fs/uf=%h want 0",
               {rd_fifo_en, video_hs, video_vs, video_de, video_data, frame_start, underflow});
    end
    repeat (3) @(negedge clk);
    tests++;
    if ({rd_fifo_en, video_hs, video_vs, video_de, video_data, frame_start, underflow} !== 30'h0) begin
      fails++;
      $display("FAIL reset_held: got %h want 0",
               {rd_fifo_en, video_hs, video_vs, video_de, video_data, frame_start, underflow});
    end
    tests++;
    if ({hd_en, hd_hs, hd_vs, hd_de, hd_data, hd_fs, hd_uf} !== 30'h0) begin
      fails++;
      $display("FAIL reset_hd: got %h want 0", {hd_en, hd_hs, hd_vs, hd_de, hd_data, hd_fs, hd_uf});
    end
  endtask

  task automatic test_timing();
    int de_cnt, en_cnt, run;
    de_cnt = 0; en_cnt = 0; run = 0;
    do_reset(1'b0, 1'b0);
    repeat (FT + 3) begin
      @(negedge clk);
      tests++;
      if ({video_hs, video_vs, video_de, rd_fifo_en, frame_start} !==
          {exp_hs(n), exp_vs(n), exp_de(n), exp_en(n), exp_fs(n)}) begin
        fails++;
        $display("FAIL timing n=%0d: got hs/vs/de/en/fs=%b want %b", n,
                 {video_hs, video_vs, video_de, rd_fifo_en, frame_start},
                 {exp_hs(n), exp_vs(n), exp_de(n), exp_en(n), exp_fs(n)});
      end
      if (video_de) de_cnt++;
      if (rd_fifo_en) begin
        en_cnt++;
        run++;
      end else if (run != 0) begin
        tests++;
        if (run !== HA) begin
          fails++;
          $display("FAIL pop_run n=%0d: got %0d want %0d", n, run, HA);
        end
        run = 0;
      end
    end
    tests++;
    if (de_cnt !== NPIX) begin
      fails++;
      $display("FAIL de_per_frame: got %0d want %0d", de_cnt, NPIX);
    end
    tests++;
    if (en_cnt !== NPIX) begin
      fails++;
      $display("FAIL pops_per_frame: got %0d want %0d", en_cnt, NPIX);
    end
  endtask

  task automatic test_data();
    do_reset(1'b0, 1'b0);
    repeat (FT + 3) begin
      @(negedge clk);
      tests++;
      if (video_data !== exp_data(n)) begin
        fails++;
        $display("FAIL data n=%0d: got %h want %h", n, video_data, exp_data(n));
      end
    end
  endtask

  task automatic test_frame_start();
    int cnt, last, first;
    cnt = 0; last = 0; first = -1;
    do_reset(1'b0, 1'b0);
    repeat (3 * FT + 3) begin
      @(negedge clk);
      if (frame_start) begin
        tests++;
        if (video_data !== 24'(cnt * NPIX) || video_de !== 1'b1) begin
          fails++;
          $display("FAIL fs_pixel n=%0d: got de=%b data=%h want de=1 data=%h", n,
                   video_de, video_data, 24'(cnt * NPIX));
        end
        if (cnt == 0) first = n;
        else begin
          tests++;
          if (n - last !== FT) begin
            fails++;
            $display("FAIL fs_spacing: got %0d want %0d", n - last, FT);
          end
        end
        last = n;
        cnt++;
      end
    end
    tests++;
    if (cnt !== 3) begin
      fails++;
      $display("FAIL fs_count: got %0d want 3", cnt);
    end
    tests++;
    if (first !== 3 + FS_POS) begin
      fails++;
      $display("FAIL fs_first: got %0d want %0d", first, 3 + FS_POS);
    end
  endtask

  task automatic test_underflow();
    do_reset(1'b0, 1'b1);
    repeat (FT + 10) begin
      @(negedge clk);
      tests++;
      if ({underflow, video_hs, video_vs, video_de, rd_fifo_en, video_data} !==
          {exp_uf(n), exp_hs(n), exp_vs(n), exp_de(n), exp_en(n), exp_data(n)}) begin
        fails++;
        $display("FAIL underflow n=%0d: got uf/hs/vs/de/en/data=%h want %h", n,
                 {underflow, video_hs, video_vs, video_de, rd_fifo_en, video_data},
                 {exp_uf(n), exp_hs(n), exp_vs(n), exp_de(n), exp_en(n), exp_data(n)});
      end
    end
    tests++;
    if (underflow !== 1'b1) begin
      fails++;
      $display("FAIL underflow_sticky: got %b want 1", underflow);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    for (int it = 0; it < 4; it++) begin
      k = (it == 0) ? (3 * HT + 6) : int'($urandom_range(40, 200));
      do_reset(1'b0, it != 0);
      repeat (k) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if ({rd_fifo_en, video_hs, video_vs, video_de, video_data, frame_start, underflow} !== 30'h0) begin
        fails++;
        $display("FAIL mid_reset k=%0d: got %h want 0", k,
                 {rd_fifo_en, video_hs, video_vs, video_de, video_data, frame_start, underflow});
      end
      @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (FT + 3) begin
        @(negedge clk);
        tests++;
        if ({underflow, video_hs, video_vs, video_de, rd_fifo_en, frame_start, video_data} !==
            {exp_uf(n), exp_hs(n), exp_vs(n), exp_de(n), exp_en(n), exp_fs(n), exp_data(n)}) begin
          fails++;
          $display("FAIL after_reset k=%0d n=%0d: got %h want %h", k, n,
                   {underflow, video_hs, video_vs, video_de, rd_fifo_en, frame_start, video_data},
                   {exp_uf(n), exp_hs(n), exp_vs(n), exp_de(n), exp_en(n), exp_fs(n), exp_data(n)});
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset(1'b1, 1'b0);
    repeat (2 * FT + 3) begin
      @(negedge clk);
      tests++;
      if ({underflow, video_hs, video_vs, video_de, rd_fifo_en, frame_start, video_data} !==
          {exp_uf(n), exp_hs(n), exp_vs(n), exp_de(n), exp_en(n), exp_fs(n), exp_data(n)}) begin
        fails++;
        $display("FAIL random n=%0d: got %h want %h", n,
                 {underflow, video_hs, video_vs, video_de, rd_fifo_en, frame_start, video_data},
                 {exp_uf(n), exp_hs(n), exp_vs(n), exp_de(n), exp_en(n), exp_fs(n), exp_data(n)});
      end
      noise = 1'($urandom_range(0, 1));
    end
    noise = 1'b0;
  endtask

  task automatic test_1080p();
    int m, rises, last, act;
    bit prev;
    m = 0; rises = 0; last = 0; act = 0; prev = 1'b0;
    @(negedge clk);
    #1 rst_hd_n = 1'b1;
    repeat (9000) begin
      @(negedge clk);
      m++;
      if (hd_hs && !prev) begin
        tests++;
        if (rises == 0 ? (m !== 3) : (m - last !== 2200)) begin
          fails++;
          $display("FAIL hd_hs_period m=%0d: got %0d want %0d", m,
                   rises == 0 ? m : m - last, rises == 0 ? 3 : 2200);
        end
        last = m;
        rises++;
      end
      prev = hd_hs;
      if (hd_de || hd_en || hd_fs) act++;
      if (m == 3 || m == 9000) begin
        tests++;
        if (hd_vs !== 1'b1) begin
          fails++;
          $display("FAIL hd_vs m=%0d: got %b want 1", m, hd_vs);
        end
      end
    end
    tests++;
    if (rises !== 5) begin
      fails++;
      $display("FAIL hd_hs_count: got %0d want 5", rises);
    end
    tests++;
    if (act !== 0 || hd_uf !== 1'b0) begin
      fails++;
      $display("FAIL hd_blank: got active=%0d uf=%b want 0/0", act, hd_uf);
    end
    rst_hd_n = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rand_pix[i] = 24'($urandom);
    test_reset();
    test_timing();
    test_data();
    test_frame_start();
    test_underflow();
    test_reset_mid();
    test_random();
    test_1080p();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
